// File: rtl/led_pkg.sv
// Shared types and default timing constants for the LED blink driver.
package led_pkg;

  localparam int unsigned DIV_40HZ      = 1250000;
  localparam int unsigned ON_TICKS_DEF  = 8;
  localparam int unsigned OFF_TICKS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } led_state_t;

endpackage : led_pkg

// File: rtl/led_chan.sv
// One LED channel: blink FSM with phase counter, remaining-blink counter
// and a one-deep pending request slot.
module led_chan
  import led_pkg::*;
#(
  parameter int unsigned ON_TICKS  = ON_TICKS_DEF,
  parameter int unsigned OFF_TICKS = OFF_TICKS_DEF,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             req,
  input  logic [CNT_W-1:0] cnt,
  output logic             led_n,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  led_state_t       state, state_n;
  logic [PH_W-1:0]  phase, phase_n;
  logic [CNT_W-1:0] remain, remain_n;
  logic             pend_vld, pend_vld_n;
  logic [CNT_W-1:0] pend_cnt, pend_cnt_n;
  logic             done_n;
  logic             req_ok;

  // Zero-count requests are dropped everywhere.
  assign req_ok = req && (cnt != '0);

  // Next-state, counters and pending-slot update.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    remain_n   = remain;
    pend_vld_n = pend_vld;
    pend_cnt_n = pend_cnt;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (req_ok) begin
          state_n  = ON;
          phase_n  = PH_W'(ON_TICKS);
          remain_n = cnt;
        end
      end

      ON: begin
        if (req_ok) begin
          pend_vld_n = 1'b1;
          pend_cnt_n = cnt;
        end
        if (tick) begin
          if (phase == PH_W'(1)) begin
            state_n = OFF;
            phase_n = PH_W'(OFF_TICKS);
          end else begin
            phase_n = phase - PH_W'(1);
          end
        end
      end

      OFF: begin
        if (req_ok) begin
          pend_vld_n = 1'b1;
          pend_cnt_n = cnt;
        end
        if (tick) begin
          if (phase == PH_W'(1)) begin
            if (remain > CNT_W'(1)) begin
              remain_n = remain - CNT_W'(1);
              state_n  = ON;
              phase_n  = PH_W'(ON_TICKS);
            end else begin
              // Sequence ends: chain pending first, then a same-cycle request.
              done_n = 1'b1;
              if (pend_vld) begin
                state_n    = ON;
                phase_n    = PH_W'(ON_TICKS);
                remain_n   = pend_cnt;
                pend_vld_n = req_ok;
              end else if (req_ok) begin
                state_n    = ON;
                phase_n    = PH_W'(ON_TICKS);
                remain_n   = cnt;
                pend_vld_n = 1'b0;
                pend_cnt_n = pend_cnt;
              end else begin
                state_n  = IDLE;
                phase_n  = '0;
                remain_n = '0;
              end
            end
          end else begin
            phase_n = phase - PH_W'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      remain   <= '0;
      pend_vld <= 1'b0;
      pend_cnt <= '0;
      led_n    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      remain   <= remain_n;
      pend_vld <= pend_vld_n;
      pend_cnt <= pend_cnt_n;
      led_n    <= (state_n != ON);
      busy     <= (state_n != IDLE);
      done     <= done_n;
    end
  end

endmodule : led_chan

// File: rtl/led_flash.sv
// Multi-channel LED blink driver: shared free-running tick prescaler
// feeding one blink FSM per channel.
module led_flash
  import led_pkg::*;
#(
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned DIV       = DIV_40HZ,
  parameter int unsigned ON_TICKS  = ON_TICKS_DEF,
  parameter int unsigned OFF_TICKS = OFF_TICKS_DEF,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CHANNELS-1:0] REQ,
  input  logic [CNT_W-1:0]    CNT,
  output logic [CHANNELS-1:0] nLOUT,
  output logic [CHANNELS-1:0] BUSY,
  output logic [CHANNELS-1:0] DONE
);

  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_W'(DIV - 1));

  // Free-running prescaler, never restarted by requests.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
    led_chan #(
      .ON_TICKS (ON_TICKS),
      .OFF_TICKS(OFF_TICKS),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk  (CLK),
      .rst_n(nRST),
      .tick (tick),
      .req  (REQ[g]),
      .cnt  (CNT),
      .led_n(nLOUT[g]),
      .busy (BUSY[g]),
      .done (DONE[g])
    );
  end

endmodule : led_flash

// File: tb/tb_led_flash.sv
// Bench for led_flash: per-scenario vector tables feeding an expected-output
// queue that is popped and compared every cycle.
module tb_led_flash;

  localparam int unsigned CH     = 3;
  localparam int unsigned DIV    = 4;
  localparam int unsigned ONT    = 2;
  localparam int unsigned OFFT   = 2;
  localparam int unsigned CW     = 4;
  localparam int          NVEC   = 256;
  localparam int          ONLEN  = int'(ONT * DIV);
  localparam int          PER    = int'((ONT + OFFT) * DIV);

  logic          CLK = 1'b0;
  logic          nRST;
  logic [CH-1:0] REQ;
  logic [CW-1:0] CNT;
  logic [CH-1:0] nLOUT;
  logic [CH-1:0] BUSY;
  logic [CH-1:0] DONE;

  typedef struct packed {
    logic [CH-1:0] req;
    logic [CW-1:0] cnt;
    logic [CH-1:0] nl;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;
  } vec_t;

  typedef struct {
    logic [CH-1:0] nl;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;
    int            idx;
  } exp_t;

  vec_t vec [NVEC];
  exp_t sbq [$];
  int   n_cmp;
  int   n_err;
  int   cyc;

  led_flash #(
    .CHANNELS (CH),
    .DIV      (DIV),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .CNT_W    (CW)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .REQ  (REQ),
    .CNT  (CNT),
    .nLOUT(nLOUT),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  // Bench-side cycle count since reset release; tick cycles are cyc % DIV == DIV-1.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic cmp(input string name, input int idx,
                     input logic [CH-1:0] act, input logic [CH-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b want %b", name, idx, act, want);
    end
  endtask

  task automatic clear_vec();
    for (int k = 0; k < NVEC; k++) begin
      vec[k] = '{req: '0, cnt: '0, nl: '1, busy: '0, done: '0};
    end
  endtask

  task automatic set_req(input int k, input logic [CH-1:0] r, input logic [CW-1:0] c);
    vec[k].req = r;
    vec[k].cnt = c;
  endtask

  // Tick-aligned sequence of n blinks whose first ON cycle is s.
  task automatic add_blinks(input int ch, input int s, input int n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < ONLEN; i++) vec[s + b*PER + i].nl[ch] = 1'b0;
      for (int i = 0; i < PER; i++)   vec[s + b*PER + i].busy[ch] = 1'b1;
    end
    vec[s + n*PER].done[ch] = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic align();
    for (int i = 0; i < int'(DIV) && (cyc % int'(DIV)) != int'(DIV) - 1; i++) step();
  endtask

  task automatic run_vectors(input int len, input string name);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      REQ = vec[k].req;
      CNT = vec[k].cnt;
      sbq.push_back('{nl: vec[k].nl, busy: vec[k].busy, done: vec[k].done, idx: k});
      @(negedge CLK);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s[%0d]: got empty queue want entry", name, k);
      end else begin
        e = sbq.pop_front();
        cmp({name, ".nLOUT"}, e.idx, nLOUT, e.nl);
        cmp({name, ".BUSY"},  e.idx, BUSY,  e.busy);
        cmp({name, ".DONE"},  e.idx, DONE,  e.done);
      end
      step();
    end
    REQ = '0;
    CNT = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    nRST  = 1'b0;
    REQ   = '0;
    CNT   = '0;
    step();
    step();

    // Requests during reset are ignored and outputs hold reset values.
    for (int k = 0; k < 4; k++) begin
      REQ = (k == 1) ? 3'b111 : 3'b000;
      CNT = 4'd2;
      @(negedge CLK);
      cmp("rst.nLOUT", k, nLOUT, 3'b111);
      cmp("rst.BUSY",  k, BUSY,  3'b000);
      cmp("rst.DONE",  k, DONE,  3'b000);
      step();
    end
    REQ  = '0;
    CNT  = '0;
    nRST = 1'b1;

    // First tick lands on cycle DIV-1 after release.
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      cmp("tick", k, CH'(dut.tick), (k == 3) ? 3'b001 : 3'b000);
      step();
    end

    align();
    clear_vec();
    set_req(0, 3'b001, 4'd1);
    add_blinks(0, 1, 1);
    run_vectors(20, "single");

    align();
    clear_vec();
    set_req(0, 3'b110, 4'd3);
    add_blinks(1, 1, 3);
    add_blinks(2, 1, 3);
    run_vectors(52, "multi");

    align();
    clear_vec();
    set_req(0, 3'b111, 4'd0);
    set_req(2, 3'b001, 4'd0);
    run_vectors(8, "zero_idle");

    align();
    clear_vec();
    set_req(0, 3'b001, 4'd1);
    set_req(3, 3'b001, 4'd0);
    set_req(9, 3'b001, 4'd0);
    add_blinks(0, 1, 1);
    run_vectors(24, "zero_busy");

    align();
    clear_vec();
    set_req(0, 3'b001, 4'd1);
    set_req(2, 3'b001, 4'd2);
    set_req(5, 3'b001, 4'd0);
    set_req(12, 3'b001, 4'd0);
    add_blinks(0, 1, 1);
    add_blinks(0, 17, 2);
    run_vectors(52, "zero_pend");

    align();
    clear_vec();
    set_req(0, 3'b001, 4'd1);
    set_req(2, 3'b001, 4'd2);
    set_req(4, 3'b001, 4'd3);
    add_blinks(0, 1, 1);
    add_blinks(0, 17, 3);
    run_vectors(68, "overwrite");

    align();
    clear_vec();
    set_req(0, 3'b100, 4'd1);
    set_req(16, 3'b100, 4'd2);
    add_blinks(2, 1, 1);
    add_blinks(2, 17, 2);
    run_vectors(52, "collide");

    align();
    clear_vec();
    set_req(0, 3'b001, 4'd1);
    set_req(3, 3'b001, 4'd2);
    set_req(16, 3'b001, 4'd1);
    add_blinks(0, 1, 1);
    add_blinks(0, 17, 2);
    add_blinks(0, 49, 1);
    run_vectors(68, "pend_collide");

    // Unaligned starts: ch0 one cycle after a tick, ch1 one cycle before one.
    align();
    clear_vec();
    set_req(1, 3'b001, 4'd1);
    set_req(3, 3'b010, 4'd1);
    for (int i = 2; i <= 8; i++)  vec[i].nl[0] = 1'b0;
    for (int i = 2; i <= 16; i++) vec[i].busy[0] = 1'b1;
    for (int i = 4; i <= 8; i++)  vec[i].nl[1] = 1'b0;
    for (int i = 4; i <= 16; i++) vec[i].busy[1] = 1'b1;
    vec[17].done = 3'b011;
    run_vectors(20, "unaligned");

    align();
    clear_vec();
    set_req(0, 3'b010, 4'd15);
    add_blinks(1, 1, 15);
    run_vectors(244, "max15");

    // Mid-sequence reset drops the LED at once and discards the pending slot.
    align();
    REQ = 3'b001;
    CNT = 4'd2;
    step();
    cmp("pre_rst.nLOUT", 0, nLOUT, 3'b110);
    REQ = 3'b001;
    CNT = 4'd3;
    step();
    REQ = '0;
    CNT = '0;
    step();
    #2;
    nRST = 1'b0;
    #1;
    cmp("mid_rst.nLOUT", 0, nLOUT, 3'b111);
    cmp("mid_rst.BUSY",  0, BUSY,  3'b000);
    cmp("mid_rst.DONE",  0, DONE,  3'b000);
    step();
    nRST = 1'b1;
    clear_vec();
    run_vectors(40, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_led_flash
